instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 182 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes ULM instruction fields into 32-bit words and writes
// them to program memory at consecutive word addresses through a 4-entry FIFO.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   base_load, base_addr         reload write pointer (held pending while busy)
//   in_valid/in_ready            field handshake
//   in_opcode, in_r0..in_r2      opcode and register fields
//   in_imm                       immediate / offset / exit code
//   wr_en, wr_addr, wr_data      memory write request, stable until wr_ack
//   wr_ack                       memory accepted the write
//   err                          one-cycle pulse after a rejected instruction
//   word_count                   words written since reset or base_load
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic [3:0]  in_r0,
    input  logic [3:0]  in_r1,
    input  logic [3:0]  in_r2,
    input  logic [23:0] in_imm,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ack,
    output logic        err,
    output logic [15:0] word_count
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned CW    = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_idx, rd_idx, rd_nxt;
    logic [CW-1:0] cnt, cnt_after_deq, cnt_next;
    logic          base_pend;
    logic [31:2]   pend_addr;
    logic          base_addr_unused;

    logic [31:0]   enc_word;
    logic          legal;
    logic          deq, enq, accept, full, apply_base;
    logic          load_word;
    logic [31:0]   next_word;

    // Low address bits are discarded: the pointer is always word aligned.
    assign base_addr_unused = ^base_addr[1:0];

    // Field encoding and legality check
    always_comb begin
        enc_word        = '0;
        legal           = 1'b1;
        enc_word[31:24] = in_opcode;
        case (in_opcode)
            8'h01, 8'h31: begin
                enc_word[23:16] = in_imm[7:0];
                legal           = (in_imm[23:8] == 16'h0000);
            end
            8'h02, 8'h30, 8'h32: enc_word[23:20] = in_r0;
            8'h03, 8'h04, 8'h05, 8'h06: enc_word[23:0] = in_imm;
            8'h07: begin
                enc_word[23:20] = in_r0;
                enc_word[19:16] = in_r1;
            end
            8'h10: begin
                enc_word[23:20] = in_r0;
                enc_word[19:0]  = in_imm[19:0];
                legal           = (in_imm[23:20] == 4'h0);
            end
            8'h11, 8'h13: begin
                enc_word[23:20] = in_r0;
                enc_word[19:16] = in_r1;
                enc_word[15:12] = in_r2;
            end
            8'h12, 8'h14: begin
                enc_word[23:20] = in_r0;
                enc_word[19:16] = in_r1;
                enc_word[15:0]  = in_imm[15:0];
                legal           = (in_imm[23:16] == 8'h00);
            end
            8'h20, 8'h22, 8'h23, 8'h24: begin
                enc_word[23:20] = in_r0;
                enc_word[19:16] = in_r1;
                enc_word[15:0]  = in_imm[15:0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Handshake: a full FIFO still accepts when its head leaves this cycle
    assign deq           = (state_q == WRITE) && wr_ack;
    assign full          = (cnt == CW'(DEPTH));
    assign in_ready      = !rst && !base_load && (!full || deq);
    assign accept        = in_valid && in_ready;
    assign enq           = accept && legal;
    assign cnt_after_deq = cnt - CW'(deq);
    assign cnt_next      = cnt_after_deq + CW'(enq);
    assign rd_nxt        = rd_idx + AW'(1);
    assign apply_base    = (state_q == IDLE) && (cnt == '0) && (base_load || base_pend);

    // Write FSM next state and next word to present on wr_data
    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        next_word = mem[rd_idx];
        case (state_q)
            IDLE: begin
                if (cnt != '0) begin
                    state_d   = WRITE;
                    load_word = 1'b1;
                end
            end
            WRITE: begin
                if (deq) begin
                    if (cnt_next != '0) begin
                        load_word = 1'b1;
                        // With only the departing word stored, the next head is the one arriving now
                        next_word = (cnt >= CW'(2)) ? mem[rd_nxt] : enc_word;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (enq) mem[wr_idx] <= enc_word;
    end

    // Pointers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            err        <= 1'b0;
            word_count <= '0;
            cnt        <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            base_pend  <= 1'b0;
            pend_addr  <= '0;
        end else begin
            err   <= accept && !legal;
            wr_en <= (state_d == WRITE);
            cnt   <= cnt_next;
            if (load_word) wr_data <= next_word;
            if (enq) wr_idx <= wr_idx + AW'(1);
            if (deq) begin
                rd_idx     <= rd_nxt;
                wr_addr    <= wr_addr + 32'd4;
                word_count <= word_count + 16'd1;
            end
            if (apply_base) begin
                wr_addr    <= base_load ? {base_addr[31:2], 2'b00} : {pend_addr, 2'b00};
                word_count <= '0;
                base_pend  <= 1'b0;
            end else if (base_load) begin
                base_pend <= 1'b1;
                pend_addr <= base_addr[31:2];
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, addresses and timing.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, base_load, in_valid, in_ready, wr_en, wr_ack, err;
    logic [31:0] base_addr, wr_addr, wr_data;
    logic [7:0]  in_opcode;
    logic [3:0]  in_r0, in_r1, in_r2;
    logic [23:0] in_imm;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] cap_addr [$];
    logic [31:0] cap_data [$];
    int          cap_cyc  [$];

    logic [7:0]  op4  [6] = '{8'h01, 8'h02, 8'h07, 8'h14, 8'h24, 8'h32};
    logic [3:0]  a4   [6] = '{4'h0, 4'h7, 4'h1, 4'h4, 4'h6, 4'h9};
    logic [3:0]  b4   [6] = '{4'h0, 4'h0, 4'h2, 4'h5, 4'h8, 4'h0};
    logic [23:0] imm4 [6] = '{24'h00002A, 24'h0, 24'h0, 24'h00BEEF, 24'h008000, 24'h0};
    logic [31:0] exp4 [6] = '{32'h012A0000, 32'h02700000, 32'h07120000,
                              32'h1445BEEF, 32'h24688000, 32'h32900000};

    instr_encoder dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_r0(in_r0), .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed memory write
    always @(posedge clk) begin
        if (!rst && wr_en && wr_ack) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cap_clear();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    // Present fields and hold until accepted; returns just after the accepting edge
    task automatic send(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [23:0] imm);
        int n;
        in_valid  = 1'b1;
        in_opcode = op;
        in_r0     = a;
        in_r1     = b;
        in_r2     = c;
        in_imm    = imm;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (cap_data.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk("write_count", 32'(cap_data.size()), 32'(n));
    endtask

    initial begin
        rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b1;
        in_opcode = 8'h11; in_r0 = '0; in_r1 = '0; in_r2 = '0; in_imm = '0; wr_ack = 1'b0;
        tick();
        tick();
        // Reset values
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Base 0x100, one reg add, ack delayed two cycles
        base_load = 1'b1; base_addr = 32'h100;
        tick();
        base_load = 1'b0;
        chk("s1_base", wr_addr, 32'h100);
        send(8'h11, 4'h3, 4'h2, 4'h1, 24'h0);
        tick();
        chk("s1_wr_en", 32'(wr_en), 32'd1);
        chk("s1_wr_data", wr_data, 32'h11321000);
        chk("s1_wr_addr", wr_addr, 32'h100);
        tick();
        chk("s1_hold_en", 32'(wr_en), 32'd1);
        chk("s1_hold_data", wr_data, 32'h11321000);
        chk("s1_hold_addr", wr_addr, 32'h100);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("s1_en_drop", 32'(wr_en), 32'd0);
        chk("s1_count", 32'(word_count), 32'd1);
        chk("s1_ptr", wr_addr, 32'h104);

        // ldzwq then jmp with ack tied high: consecutive writes
        do_reset();
        cap_clear();
        wr_ack = 1'b1;
        send(8'h10, 4'h5, 4'h0, 4'h0, 24'h0ABCD0);
        send(8'h05, 4'h0, 4'h0, 4'h0, 24'hFFFFFE);
        wait_writes(2);
        if (cap_data.size() == 2) begin
            chk("s2_data0", cap_data[0], 32'h105ABCD0);
            chk("s2_addr0", cap_addr[0], 32'h0);
            chk("s2_data1", cap_data[1], 32'h05FFFFFE);
            chk("s2_addr1", cap_addr[1], 32'h4);
            chk("s2_gap", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
        end
        tick();
        wr_ack = 1'b0;
        chk("s2_count", 32'(word_count), 32'd2);

        // Illegal opcode and oversized ldzwq immediate
        do_reset();
        cap_clear();
        send(8'h99, 4'h1, 4'h1, 4'h1, 24'h0);
        chk("s3_err0", 32'(err), 32'd1);
        send(8'h10, 4'h5, 4'h0, 4'h0, 24'h100000);
        chk("s3_err1", 32'(err), 32'd1);
        tick();
        chk("s3_err_pulse", 32'(err), 32'd0);
        repeat (5) tick();
        chk("s3_no_write", 32'(cap_data.size()), 32'd0);
        chk("s3_wr_en", 32'(wr_en), 32'd0);
        chk("s3_count", 32'(word_count), 32'd0);

        // Backpressure: FIFO fills, then six writes drain without gaps
        do_reset();
        cap_clear();
        for (int i = 0; i < 4; i++) send(op4[i], a4[i], b4[i], 4'h0, imm4[i]);
        in_valid = 1'b1; in_opcode = op4[4]; in_r0 = a4[4]; in_r1 = b4[4]; in_imm = imm4[4];
        #1;
        chk("s4_full", 32'(in_ready), 32'd0);
        tick();
        chk("s4_still_full", 32'(in_ready), 32'd0);
        chk("s4_head", wr_data, exp4[0]);
        wr_ack = 1'b1;
        send(op4[4], a4[4], b4[4], 4'h0, imm4[4]);
        send(op4[5], a4[5], b4[5], 4'h0, imm4[5]);
        wait_writes(6);
        if (cap_data.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("s4_data%0d", i), cap_data[i], exp4[i]);
                chk($sformatf("s4_addr%0d", i), cap_addr[i], 32'(4 * i));
                if (i > 0) chk($sformatf("s4_gap%0d", i), 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
            end
        end
        wr_ack = 1'b0;
        tick();
        chk("s4_count", 32'(word_count), 32'd6);

        // Reset mid-WRITE discards buffered words
        do_reset();
        cap_clear();
        for (int i = 0; i < 3; i++) send(8'h20, 4'(i), 4'h2, 4'h0, 24'h000010);
        chk("s5_writing", 32'(wr_en), 32'd1);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("s5_en_drop", 32'(wr_en), 32'd0);
        chk("s5_ready_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        wr_ack = 1'b1;
        repeat (8) tick();
        chk("s5_no_write", 32'(cap_data.size()), 32'd0);
        chk("s5_wr_en", 32'(wr_en), 32'd0);
        chk("s5_count", 32'(word_count), 32'd0);
        wr_ack = 1'b0;

        // Pointer wrap from the top of the address space
        base_load = 1'b1; base_addr = 32'hFFFFFFFF;
        tick();
        base_load = 1'b0;
        chk("s6_base", wr_addr, 32'hFFFFFFFC);
        cap_clear();
        wr_ack = 1'b1;
        send(8'h31, 4'h0, 4'h0, 4'h0, 24'h000041);
        send(8'h30, 4'h3, 4'h0, 4'h0, 24'h0);
        wait_writes(2);
        if (cap_data.size() == 2) begin
            chk("s6_addr0", cap_addr[0], 32'hFFFFFFFC);
            chk("s6_data0", cap_data[0], 32'h31410000);
            chk("s6_addr1", cap_addr[1], 32'h00000000);
            chk("s6_data1", cap_data[1], 32'h30300000);
        end
        tick();
        wr_ack = 1'b0;
        chk("s6_count", 32'(word_count), 32'd2);

        // base_load during WRITE is deferred until idle and empty
        send(8'h13, 4'h1, 4'h2, 4'h3, 24'h0);
        tick();
        chk("s7_writing", 32'(wr_en), 32'd1);
        base_load = 1'b1; base_addr = 32'h200;
        tick();
        base_load = 1'b0;
        chk("s7_ptr_held", wr_addr, 32'h4);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("s7_ptr_step", wr_addr, 32'h8);
        chk("s7_count_step", 32'(word_count), 32'd3);
        tick();
        chk("s7_ptr_base", wr_addr, 32'h200);
        chk("s7_count_clr", 32'(word_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
